// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin scheduler sharing one UART TX serializer among N clients
module uart_tx_arbiter #(
  parameter  int N        = 4,
  parameter  int SIZE     = 8,
  parameter  int START_TO = 16,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int CW       = $clog2(START_TO + 1)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N-1:0]    REQ,
  input  logic [N*SIZE-1:0] DATA,
  output logic [N-1:0]    ACK,
  output logic [IW-1:0]   GNT_ID,
  output logic [SIZE-1:0] TX_DATA,
  output logic            TX_RQ,
  input  logic            TX_BUSY,
  output logic            BUSY,
  output logic            START_ERR
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LAUNCH     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   gsel;
  logic            found;
  logic [SIZE-1:0] gdata;
  logic [IW-1:0]   ptr_next;
  int              idx;

  // Search REQ starting at ptr, wrapping at N rather than at 2^IW.
  always_comb begin
    gsel  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && REQ[idx[IW-1:0]]) begin
        found = 1'b1;
        gsel  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    gdata = '0;
    for (int k = 0; k < N; k++) begin
      if (gsel == IW'(k)) gdata = DATA[k*SIZE +: SIZE];
    end
  end

  always_comb begin
    if (int'(gsel) == N - 1) ptr_next = '0;
    else                     ptr_next = gsel + IW'(1);
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      ACK       <= '0;
      TX_RQ     <= 1'b0;
      START_ERR <= 1'b0;
      TX_DATA   <= '0;
      GNT_ID    <= '0;
    end else begin
      ACK       <= '0;
      TX_RQ     <= 1'b0;
      START_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (!TX_BUSY && found) begin
            TX_DATA   <= gdata;
            GNT_ID    <= gsel;
            ACK[gsel] <= 1'b1;
            TX_RQ     <= 1'b1;
            ptr       <= ptr_next;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= '0;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (TX_BUSY) begin
            state <= WAIT_DONE;
          end else begin
            cnt <= cnt + CW'(1);
            // Error fires on the edge the counter reaches START_TO-1; the frame is dropped.
            if (cnt == CW'(START_TO - 2)) begin
              START_ERR <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        WAIT_DONE: begin
          if (!TX_BUSY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table-driven bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int SIZE = 8;
  localparam int START_TO = 16;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*SIZE-1:0] data;
  logic [N-1:0]    ack;
  logic [1:0]      gnt_id;
  logic [SIZE-1:0] tx_data;
  logic            tx_rq;
  logic            tx_busy;
  logic            busy;
  logic            start_err;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  ser_cnt = 0;
  bit  ser_en = 1'b1;
  bit  busy_force = 1'b0;

  uart_tx_arbiter #(.N(N), .SIZE(SIZE), .START_TO(START_TO)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .DATA(data), .ACK(ack), .GNT_ID(gnt_id),
    .TX_DATA(tx_data), .TX_RQ(tx_rq), .TX_BUSY(tx_busy), .BUSY(busy), .START_ERR(start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Serializer model: busy for 10 cycles after seeing a start request.
  always @(negedge clk) begin
    if (!ser_en) ser_cnt = 0;
    else if (tx_rq && ser_cnt == 0) ser_cnt = 10;
    else if (ser_cnt > 0) ser_cnt = ser_cnt - 1;
  end
  assign tx_busy = (ser_cnt != 0) || busy_force;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ack != '0) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    bit                rst;
    logic [N-1:0]      req;
    logic [N*SIZE-1:0] data;
    logic [N-1:0]      exp_ack;
    logic [1:0]        exp_gnt;
    logic [SIZE-1:0]   exp_data;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit ok;
    int rq_cnt;
    int t0;
    int errs;
    vecs[0]  = '{1'b1, 4'b0100, 32'h13A51110, 4'b0100, 2'd2, 8'hA5};
    vecs[1]  = '{1'b1, 4'b1111, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[2]  = '{1'b0, 4'b1111, 32'h13121110, 4'b0010, 2'd1, 8'h11};
    vecs[3]  = '{1'b0, 4'b1111, 32'h13121110, 4'b0100, 2'd2, 8'h12};
    vecs[4]  = '{1'b0, 4'b1111, 32'h13121110, 4'b1000, 2'd3, 8'h13};
    vecs[5]  = '{1'b0, 4'b1111, 32'h13121110, 4'b0001, 2'd0, 8'h10};
    vecs[6]  = '{1'b1, 4'b1010, 32'h13121110, 4'b0010, 2'd1, 8'h11};
    vecs[7]  = '{1'b0, 4'b1010, 32'h13121110, 4'b1000, 2'd3, 8'h13};
    vecs[8]  = '{1'b0, 4'b1000, 32'h13121110, 4'b1000, 2'd3, 8'h13};
    vecs[9]  = '{1'b0, 4'b1010, 32'h13121110, 4'b0010, 2'd1, 8'h11};
    vecs[10] = '{1'b0, 4'b1010, 32'h13121110, 4'b1000, 2'd3, 8'h13};
    vecs[11] = '{1'b0, 4'b1010, 32'h13121110, 4'b0010, 2'd1, 8'h11};

    rst_n = 1'b0;
    req = '0;
    data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_tx_rq", 32'(tx_rq), 32'd0);
    chk("rst_start_err", 32'(start_err), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].rst) do_reset();
      data = vecs[v].data;
      req = vecs[v].req;
      wait_ack(ok);
      if (ok) begin
        chk($sformatf("v%0d_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
        chk($sformatf("v%0d_gnt", v), 32'(gnt_id), 32'(vecs[v].exp_gnt));
        chk($sformatf("v%0d_tx_data", v), 32'(tx_data), 32'(vecs[v].exp_data));
        chk($sformatf("v%0d_tx_rq", v), 32'(tx_rq), 32'd1);
        chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", v), 32'(ack), 32'd0);
        rq_cnt = 0;
        errs = 0;
        for (int i = 0; i < 100 && busy; i++) begin
          if (tx_rq) rq_cnt++;
          if (tx_data !== vecs[v].exp_data) errs++;
          @(negedge clk);
        end
        chk($sformatf("v%0d_frame_end", v), 32'(busy), 32'd0);
        chk($sformatf("v%0d_extra_tx_rq", v), 32'(rq_cnt), 32'd0);
        chk($sformatf("v%0d_tx_data_hold", v), 32'(errs), 32'd0);
      end
    end

    // Dead serializer: start error 16 cycles after the start request, then next grant.
    ser_en = 1'b0;
    do_reset();
    data = 32'h13121110;
    req = 4'b0001;
    wait_ack(ok);
    t0 = cyc;
    req = 4'b0100;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (start_err) begin ok = 1'b1; break; end
    end
    chk("dead_err_seen", 32'(ok), 32'd1);
    chk("dead_err_delay", 32'(cyc - t0), 32'd16);
    chk("dead_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("dead_err_pulse", 32'(start_err), 32'd0);
    chk("dead_next_ack", 32'(ack), 32'b0100);
    chk("dead_next_data", 32'(tx_data), 32'h12);
    req = '0;
    for (int i = 0; i < 40 && (busy || start_err); i++) @(negedge clk);
    chk("dead_second_end", 32'(busy), 32'd0);

    // Reset while waiting for frame done.
    ser_en = 1'b1;
    do_reset();
    req = 4'b0001;
    wait_ack(ok);
    repeat (5) @(negedge clk);
    chk("wd_busy_before_rst", 32'(busy), 32'd1);
    busy_force = 1'b1;
    ser_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("wd_rst_busy", 32'(busy), 32'd0);
    chk("wd_rst_tx_data", 32'(tx_data), 32'd0);
    chk("wd_rst_gnt", 32'(gnt_id), 32'd0);
    chk("wd_rst_ack", 32'(ack), 32'd0);
    chk("wd_rst_tx_rq", 32'(tx_rq), 32'd0);
    rst_n = 1'b1;
    errs = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack != '0 || tx_rq) errs++;
    end
    chk("wd_no_grant_busy", 32'(errs), 32'd0);
    busy_force = 1'b0;
    @(negedge clk);
    chk("wd_grant_after", 32'(ack), 32'b0001);
    req = '0;
    for (int i = 0; i < 40 && (busy || start_err); i++) @(negedge clk);

    // TX_BUSY high for 7 cycles after reset release.
    busy_force = 1'b1;
    do_reset();
    req = 4'b1000;
    errs = 0;
    repeat (7) begin
      @(negedge clk);
      if (ack != '0 || tx_rq) errs++;
    end
    chk("rel_no_grant", 32'(errs), 32'd0);
    busy_force = 1'b0;
    @(negedge clk);
    chk("rel_ack3", 32'(ack), 32'b1000);
    chk("rel_tx_rq", 32'(tx_rq), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
